// File: rtl/demux_pkg.sv
// Shared definitions for the 8:1 deserializer: FSM state encoding and
// default word/slot widths. Used by demux_8_deser and its helpers.
package demux_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_SEL_W = 3;

    // PARITY is only entered when the design is built with PARITY_EN.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

endpackage

// File: rtl/demux_8_deser_out_reg_hs.sv
// Single-entry valid/ready holding register. A load is accepted when the
// register is empty or is being consumed in the same cycle; otherwise the
// incoming word is dropped and a one-cycle overrun pulse is raised.
module out_reg_hs #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_q,
    output logic             o_valid,
    output logic             o_overrun
);

    logic [WIDTH-1:0] r_q;
    logic             r_valid;
    logic             r_overrun;
    logic             w_accept;

    assign w_accept = i_load && (!r_valid || i_ready);

    // Hold, load or drain the word; flag a dropped load as overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q       <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= i_load && r_valid && !i_ready;
            if (w_accept) begin
                r_q     <= i_data;
                r_valid <= 1'b1;
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_q       = r_q;
    assign o_valid   = r_valid;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/demux_8_deser.sv
// Receive-side 1:8 deserializer. Captures one serial bit per din_valid in
// slot order 0..WIDTH-1 (LSB first) and presents the word through a
// valid/ready holding register. The current slot is driven out so a
// transmit mux can lock its select to it.
// Optional macro PARITY_EN: adds an even-parity bit after each word;
// without it par_err is constant 0.
module demux_8_deser
    import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEL_W = DEF_SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_valid,
    input  logic             frame_start,
    output logic [SEL_W-1:0] slot,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    input  logic             q_ready,
    output logic             overrun,
    output logic             frame_err,
    output logic             par_err
);

    state_t           r_state;
    logic [SEL_W-1:0] r_slot;
    logic [WIDTH-1:0] r_shreg;
    logic             r_frame_err;
    logic [WIDTH-1:0] w_merged;
    logic             w_last;
    logic             w_load;
    logic [WIDTH-1:0] w_load_word;

    assign w_last = (r_slot == SEL_W'(WIDTH - 1));

    // Shift register with the incoming bit dropped into the current slot;
    // at the last slot this is the complete word.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_merge
            assign w_merged[gi] = (r_slot == SEL_W'(gi)) ? din : r_shreg[gi];
        end
    endgenerate

`ifdef PARITY_EN
    logic r_par_err;
    logic w_par_ok;

    // Even parity: the parity bit equals the XOR of the data bits.
    assign w_par_ok    = (din == ^r_shreg);
    assign w_load      = din_valid && !frame_start && (r_state == PARITY) && w_par_ok;
    assign w_load_word = r_shreg;
    assign par_err     = r_par_err;
`else
    assign w_load      = din_valid && !frame_start && (r_state == SHIFT) && w_last;
    assign w_load_word = w_merged;
    assign par_err     = 1'b0;
`endif

    // Frame FSM: slot counter, shift register and error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_slot      <= '0;
            r_shreg     <= '0;
            r_frame_err <= 1'b0;
`ifdef PARITY_EN
            r_par_err   <= 1'b0;
`endif
        end else begin
            r_frame_err <= 1'b0;
`ifdef PARITY_EN
            r_par_err   <= 1'b0;
`endif
            if (din_valid && frame_start) begin
                // New frame; anything outside IDLE is an aborted partial word.
                r_frame_err <= (r_state != IDLE);
                r_shreg     <= {{(WIDTH-1){1'b0}}, din};
                r_slot      <= SEL_W'(1);
                r_state     <= SHIFT;
            end else if (din_valid) begin
                case (r_state)
                    SHIFT: begin
                        r_shreg <= w_merged;
                        if (w_last) begin
                            r_slot  <= '0;
`ifdef PARITY_EN
                            r_state <= PARITY;
`else
                            r_state <= IDLE;
`endif
                        end else begin
                            r_slot <= r_slot + SEL_W'(1);
                        end
                    end
`ifdef PARITY_EN
                    PARITY: begin
                        r_par_err <= !w_par_ok;
                        r_state   <= IDLE;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    assign slot      = r_slot;
    assign frame_err = r_frame_err;

    out_reg_hs #(
        .WIDTH (WIDTH)
    ) u_out_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_load),
        .i_data    (w_load_word),
        .i_ready   (q_ready),
        .o_q       (q),
        .o_valid   (q_valid),
        .o_overrun (overrun)
    );

endmodule

// File: tb/tb_demux_8_deser.sv
// Directed/randomized bench for demux_8_deser. A frame-level model tracks
// the expected output word, q_valid, slot and error pulses.
module tb_demux_8_deser;

    localparam int WIDTH = 8;
    localparam int SEL_W = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             din;
    logic             din_valid;
    logic             frame_start;
    logic             q_ready;
    logic [SEL_W-1:0] slot;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic             overrun;
    logic             frame_err;
    logic             par_err;

    int checks   = 0;
    int failures = 0;

    // Reference state
    logic [WIDTH-1:0] m_q;
    bit               m_qv;
    bit               m_in_frame;
    int               m_slot;

    demux_8_deser #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .frame_start (frame_start),
        .slot        (slot),
        .q           (q),
        .q_valid     (q_valid),
        .q_ready     (q_ready),
        .overrun     (overrun),
        .frame_err   (frame_err),
        .par_err     (par_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock; the model decides what the output register must show.
    task automatic tick(input bit complete, input logic [WIDTH-1:0] word,
                        input bit exp_ferr, input bit exp_perr);
        bit exp_ovr;
        exp_ovr = 1'b0;
        if (complete) begin
            if (!m_qv || q_ready) begin
                m_q  = word;
                m_qv = 1'b1;
            end else begin
                exp_ovr = 1'b1;
            end
        end else if (m_qv && q_ready) begin
            m_qv = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("q_valid", 32'(q_valid), 32'(m_qv));
        if (m_qv) chk("q", 32'(q), 32'(m_q));
        chk("overrun", 32'(overrun), 32'(exp_ovr));
        chk("frame_err", 32'(frame_err), 32'(exp_ferr));
        chk("par_err", 32'(par_err), 32'(exp_perr));
    endtask

    // Idle gap cycles (with junk on din/frame_start), then one qualified bit.
    task automatic send_bit(input logic b, input bit fs, input int gap, input bit complete,
                            input logic [WIDTH-1:0] word, input bit perr);
        bit ferr;
        chk("slot", 32'(slot), 32'(m_slot));
        for (int g = 0; g < gap; g++) begin
            din_valid   = 1'b0;
            din         = 1'($urandom);
            frame_start = 1'($urandom);
            tick(1'b0, '0, 1'b0, 1'b0);
            chk("slot_hold", 32'(slot), 32'(m_slot));
        end
        ferr        = fs && m_in_frame;
        din_valid   = 1'b1;
        din         = b;
        frame_start = fs;
        tick(complete, word, ferr, perr);
        din_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic send_frame(input logic [WIDTH-1:0] word, input int maxgap, input bit flip);
        bit cmpl;
        for (int k = 0; k < WIDTH; k++) begin
`ifdef PARITY_EN
            cmpl = 1'b0;
`else
            cmpl = (k == WIDTH - 1);
`endif
            send_bit(word[k], (k == 0), int'($urandom_range(maxgap, 0)), cmpl, word, 1'b0);
            m_in_frame = 1'b1;
            m_slot     = (k + 1) % WIDTH;
`ifndef PARITY_EN
            if (k == WIDTH - 1) m_in_frame = 1'b0;
`endif
        end
`ifdef PARITY_EN
        send_bit((^word) ^ flip, 1'b0, int'($urandom_range(maxgap, 0)), !flip, word, flip);
        m_in_frame = 1'b0;
`else
        if (flip) chk("flip_unused", 32'(flip), 32'(0));
`endif
    endtask

    task automatic send_partial(input int n);
        for (int k = 0; k < n; k++) begin
            send_bit(1'($urandom), (k == 0), 0, 1'b0, '0, 1'b0);
            m_in_frame = 1'b1;
            m_slot     = k + 1;
        end
    endtask

    initial begin
        rst_n = 1'b0; din = 1'b0; din_valid = 1'b0; frame_start = 1'b0; q_ready = 1'b0;
        m_q = '0; m_qv = 1'b0; m_in_frame = 1'b0; m_slot = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_q", 32'(q), 32'(0));
        chk("rst_q_valid", 32'(q_valid), 32'(0));
        chk("rst_slot", 32'(slot), 32'(0));
        chk("rst_overrun", 32'(overrun), 32'(0));
        chk("rst_frame_err", 32'(frame_err), 32'(0));
        chk("rst_par_err", 32'(par_err), 32'(0));
        rst_n = 1'b1;

        // Basic frame 0x4D, consumed immediately
        q_ready = 1'b1;
        send_frame(8'h4D, 0, 1'b0);
        chk("basic_4D", 32'(q), 32'h4D);
        tick(1'b0, '0, 1'b0, 1'b0);

        // Held word, then a second frame overruns
        q_ready = 1'b0;
        send_frame(8'h4D, 0, 1'b0);
        send_frame(8'hFF, 0, 1'b0);
        chk("hold_4D", 32'(q), 32'h4D);
        tick(1'b0, '0, 1'b0, 1'b0);
        q_ready = 1'b1;
        tick(1'b0, '0, 1'b0, 1'b0);

        // Abort after 3 bits, then a fresh frame
        send_partial(3);
        send_frame(8'($urandom), 0, 1'b0);
        tick(1'b0, '0, 1'b0, 1'b0);

        // Random words with gaps and random back-pressure
        for (int f = 0; f < 6; f++) begin
            q_ready = 1'($urandom);
            send_frame(8'($urandom), 5, 1'b0);
        end
        q_ready = 1'b1;
        tick(1'b0, '0, 1'b0, 1'b0);

        // Asynchronous reset mid-frame while a word is held
        q_ready = 1'b0;
        send_frame(8'($urandom), 0, 1'b0);
        send_partial(5);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_q", 32'(q), 32'(0));
        chk("arst_q_valid", 32'(q_valid), 32'(0));
        chk("arst_slot", 32'(slot), 32'(0));
        m_q = '0; m_qv = 1'b0; m_in_frame = 1'b0; m_slot = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        q_ready = 1'b1;
        send_frame(8'($urandom), 0, 1'b0);
        tick(1'b0, '0, 1'b0, 1'b0);

        // Back-to-back frames with no gap
        for (int f = 0; f < 5; f++) send_frame(8'($urandom), 0, 1'b0);
        tick(1'b0, '0, 1'b0, 1'b0);

`ifdef PARITY_EN
        // Correct and incorrect parity on 0x4D
        send_frame(8'h4D, 0, 1'b0);
        chk("par_ok_4D", 32'(q), 32'h4D);
        tick(1'b0, '0, 1'b0, 1'b0);
        send_frame(8'h4D, 0, 1'b1);
        chk("par_bad_qv", 32'(q_valid), 32'(0));
        tick(1'b0, '0, 1'b0, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
